// File: rtl/obc_dft_pkg.sv
// Shared definitions for the OBC DFT datapath: controller states, datapath
// widths and the per-bin OBC offset constants that sibling instances select.
package obc_dft_pkg;

  // Width of the ROM partial sum, the accumulator and the result.
  localparam int ROM_W = 32;
  // Number of DFT points, which is also the number of parallel sample lanes.
  localparam int N_PTS = 16;
  // Slice index width; this covers the largest legal sample width of 16.
  localparam int K_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } obc_state_e;

  // OBC offset constant per DFT bin. Each entry is -(sum of that bin's
  // coefficients) * 2^(W-1) in ROM scaling. The ROM generator regenerates
  // this table whenever it changes the coefficient scaling.
  localparam logic signed [ROM_W-1:0] BIN_OFFSET [N_PTS] = '{
    32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0,
    32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0
  };

  // Returns the offset constant for a bin, so an instance can write
  // .OFFSET(bin_offset(4'd3)).
  function automatic logic signed [ROM_W-1:0] bin_offset(input logic [3:0] bin);
    return BIN_OFFSET[bin];
  endfunction

endpackage

// File: rtl/obc_slice_shifter.sv
// Sixteen-lane sample register. Each lane loads in parallel and then shifts
// right, so that bit 0 of every lane always holds the current bit-slice.
module obc_slice_shifter
  import obc_dft_pkg::*;
#(
  parameter int W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic               clear_i,
  input  logic [N_PTS*W-1:0] samples_i,
  output logic [N_PTS-1:0]   slice_x_o
);

  logic [W-1:0] lane_q [N_PTS];

  // Load, shift or clear the lanes. Clearing on the last slice keeps slice_x
  // at zero outside RUN without any output gating.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_PTS; i++) lane_q[i] <= '0;
    end else if (load_i) begin
      for (int i = 0; i < N_PTS; i++) lane_q[i] <= samples_i[i*W +: W];
    end else if (clear_i) begin
      for (int i = 0; i < N_PTS; i++) lane_q[i] <= '0;
    end else if (shift_i) begin
      for (int i = 0; i < N_PTS; i++) lane_q[i] <= lane_q[i] >> 1;
    end else begin
      for (int i = 0; i < N_PTS; i++) lane_q[i] <= lane_q[i];
    end
  end

  // Bit 0 of each lane forms the slice presented to the ROM stage.
  always_comb begin
    slice_x_o = '0;
    for (int i = 0; i < N_PTS; i++) slice_x_o[i] = lane_q[i][0];
  end

endmodule

// File: rtl/obc_slice_accumulator.sv
// Bit-serial OBC controller. It feeds one bit-slice per cycle (LSB first) to
// the ROM stage and accumulates the returned partial sums weighted by 2^k.
// After the last slice it adds the offset, scales the sum and emits one
// result per frame.
module obc_slice_accumulator
  import obc_dft_pkg::*;
#(
  parameter int                      W         = 8,
  parameter logic signed [ROM_W-1:0] OFFSET    = 32'sd0,
  parameter int                      OUT_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_PTS*W-1:0] samples,
  output logic               ready,
  output logic [N_PTS-1:0]   slice_x,
  output logic               slice_m,
  input  logic [ROM_W-1:0]   romout,
  output logic [ROM_W-1:0]   y,
  output logic               y_valid
);

  obc_state_e              state_q;
  logic [K_W-1:0]          k_q;
  logic signed [ROM_W-1:0] acc_q;
  logic signed [ROM_W-1:0] acc_d;
  logic signed [ROM_W-1:0] sum_s;
  logic signed [ROM_W-1:0] y_d;
  logic [ROM_W-1:0]        y_q;
  logic                    y_valid_q;
  logic                    ready_q;
  logic                    slice_m_q;
  logic                    last_s;
  logic                    load_s;
  logic                    shift_s;
  logic                    clear_s;

  // Next accumulator value and result. All arithmetic wraps at 32 bits.
  always_comb begin
    acc_d   = acc_q + ($signed(romout) <<< k_q);
    sum_s   = acc_q + OFFSET;
    y_d     = sum_s >>> OUT_SHIFT;
    last_s  = (k_q == K_W'(W - 1));
    load_s  = (state_q == ST_IDLE) && start;
    shift_s = (state_q == ST_RUN) && !last_s;
    clear_s = (state_q == ST_RUN) && last_s;
  end

  obc_slice_shifter #(
    .W (W)
  ) u_shifter (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (load_s),
    .shift_i   (shift_s),
    .clear_i   (clear_s),
    .samples_i (samples),
    .slice_x_o (slice_x)
  );

  // Frame FSM with its slice counter, accumulator and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ready_q   <= 1'b1;
      slice_m_q <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          slice_m_q <= 1'b0;
          if (start) begin
            state_q <= ST_RUN;
            k_q     <= '0;
            acc_q   <= '0;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          if (last_s) begin
            state_q   <= ST_DONE;
            k_q       <= '0;
            slice_m_q <= 1'b0;
          end else begin
            k_q       <= k_q + K_W'(1);
            // Raise the mode bit as the counter moves onto the MSB slice.
            slice_m_q <= (k_q == K_W'(W - 2));
          end
        end
        ST_DONE: begin
          y_q       <= y_d;
          y_valid_q <= 1'b1;
          ready_q   <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          k_q       <= '0;
          ready_q   <= 1'b1;
          slice_m_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = ready_q;
  assign slice_m = slice_m_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_obc_slice_accumulator.sv
// Self-checking bench for obc_slice_accumulator. Two instances share the
// stimulus: one uses OFFSET=0 and the other uses OFFSET=16. The ROM stage is
// stubbed as popcount(slice_x), negated on the MSB slice. With that stub the
// expected result is (sum of signed samples + OFFSET) >>> 1.
module tb_obc_slice_accumulator;

  localparam int W     = 8;
  localparam int NP    = 16;
  localparam int OFF_B = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic [NP*W-1:0]   samples;
  logic              ready0, ready1;
  logic [NP-1:0]     slice_x0, slice_x1;
  logic              slice_m0, slice_m1;
  logic [31:0]       romout0, romout1;
  logic [31:0]       y0, y1;
  logic              y_valid0, y_valid1;
  int                cnt0, cnt1;

  int n_vec = 0;
  int n_err = 0;

  obc_slice_accumulator #(.W(W), .OFFSET(32'sd0), .OUT_SHIFT(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .samples(samples), .ready(ready0),
    .slice_x(slice_x0), .slice_m(slice_m0), .romout(romout0), .y(y0),
    .y_valid(y_valid0)
  );

  obc_slice_accumulator #(.W(W), .OFFSET(32'sd16), .OUT_SHIFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .samples(samples), .ready(ready1),
    .slice_x(slice_x1), .slice_m(slice_m1), .romout(romout1), .y(y1),
    .y_valid(y_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM stub for each instance.
  always_comb begin
    cnt0    = $countones(slice_x0);
    cnt1    = $countones(slice_x1);
    romout0 = slice_m0 ? 32'(-cnt0) : 32'(cnt0);
    romout1 = slice_m1 ? 32'(-cnt1) : 32'(cnt1);
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Reference: the DFT term is simply the signed sum of samples plus offset, halved.
  function automatic logic [31:0] model_y(input logic [NP*W-1:0] s, input int off);
    logic signed [31:0]  sum;
    logic signed [W-1:0] t;
    sum = 32'sd0;
    for (int i = 0; i < NP; i++) begin
      t   = s[i*W +: W];
      sum = sum + t;
    end
    sum = sum + off;
    return sum >>> 1;
  endfunction

  function automatic logic [NP-1:0] exp_slice(input logic [NP*W-1:0] s, input int n);
    logic [NP-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) r[i] = (n < W) ? s[i*W + n] : 1'b0;
    return r;
  endfunction

  function automatic logic [NP*W-1:0] rand_samples();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One frame: start pulse, per-cycle slice checks, latency and result checks.
  task automatic run_frame(input logic [NP*W-1:0] s, input bit poke_busy);
    int n;
    bit seen;
    @(negedge clk);
    samples = s;
    start   = 1'b1;
    check_val("rdy_idle", 32'(ready0), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (n < W + 6 && !seen) begin
      @(negedge clk);
      if (y_valid0) begin
        seen = 1'b1;
      end else begin
        check_val("busy_rdy", 32'(ready0), 32'd0);
        check_val("slice_x", 32'(slice_x0), 32'(exp_slice(s, n)));
        check_val("slice_x_b", 32'(slice_x1), 32'(exp_slice(s, n)));
        check_val("slice_m", 32'(slice_m0), 32'(n == W - 1));
        if (poke_busy && n == 2) begin
          samples = rand_samples();
          start   = 1'b1;
        end
        if (n == 4) start = 1'b0;
        @(posedge clk);
        n++;
      end
    end
    check_val("yv_seen", 32'(seen), 32'd1);
    check_val("latency", n, W + 1);
    check_val("yv_b", 32'(y_valid1), 32'd1);
    check_val("y_off0", y0, model_y(s, 0));
    check_val("y_off16", y1, model_y(s, OFF_B));
    @(negedge clk);
    check_val("yv_pulse", 32'(y_valid0), 32'd0);
    check_val("y_hold", y0, model_y(s, 0));
  endtask

  // start held high: three back-to-back frames with a W+2 cycle period.
  task automatic held_start();
    logic [NP*W-1:0] s;
    int pulses[$];
    int n;
    s = {16{8'h02}};
    @(negedge clk);
    samples = s;
    start   = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 40 && pulses.size() < 3) begin
      @(negedge clk);
      check_val("held_rdy", 32'(ready0), 32'(n % (W + 2) == W + 1));
      if (y_valid0) begin
        pulses.push_back(n);
        check_val("held_y", y0, model_y(s, 0));
        check_val("held_y_b", y1, model_y(s, OFF_B));
      end
      if (pulses.size() == 3) begin
        start = 1'b0;
      end else begin
        @(posedge clk);
        n++;
      end
    end
    check_val("held_cnt", pulses.size(), 3);
    if (pulses.size() == 3) begin
      check_val("held_first", pulses[0], W + 1);
      check_val("held_gap1", pulses[1] - pulses[0], W + 2);
      check_val("held_gap2", pulses[2] - pulses[1], W + 2);
    end
    repeat (W + 4) @(negedge clk);
  endtask

  // Reset in the 4th RUN cycle aborts the frame without a result pulse.
  task automatic reset_mid();
    int bad;
    @(negedge clk);
    samples = rand_samples();
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("pre_rst_busy", 32'(ready0), 32'd0);
    rst = 1'b1;
    #1;
    check_val("arst_rdy", 32'(ready0), 32'd1);
    check_val("arst_x", 32'(slice_x0), 32'd0);
    check_val("arst_m", 32'(slice_m0), 32'd0);
    check_val("arst_y", y0, 32'd0);
    check_val("arst_yv", 32'(y_valid0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (y_valid0 || y_valid1) bad++;
    end
    check_val("rst_no_yv", bad, 0);
    check_val("rst_y_kept", y0, 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    samples = '0;
    repeat (2) @(negedge clk);
    check_val("rst_rdy", 32'(ready0), 32'd1);
    check_val("rst_x", 32'(slice_x0), 32'd0);
    check_val("rst_m", 32'(slice_m0), 32'd0);
    check_val("rst_y", y0, 32'd0);
    check_val("rst_yv", 32'(y_valid0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_frame({16{8'h01}}, 1'b0);
    run_frame({16{8'h80}}, 1'b0);
    run_frame({{120{1'b0}}, 8'h7F}, 1'b0);
    held_start();
    reset_mid();
    run_frame({16{8'h7F}}, 1'b0);
    run_frame(rand_samples(), 1'b1);

    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(rand_samples(), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
